// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus width, program counter reset value and bus word type.
package cpu_pkg;

  localparam int unsigned BUS_W          = 4;
  localparam int unsigned PC_RESET_VALUE = 0;

  typedef logic [BUS_W-1:0] bus_word_t;

endpackage

// File: rtl/bus_driver.sv
// Gated bus output shared by CPU registers. With PC_TRISTATE_EN defined the
// disabled output floats (Z); otherwise it reads all zeros for OR/mux buses.
module bus_driver #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] value,
  input  logic             enable,
`ifdef PC_TRISTATE_EN
  output wire logic [WIDTH-1:0] bus
`else
  output logic      [WIDTH-1:0] bus
`endif
);

`ifdef PC_TRISTATE_EN
  assign bus = enable ? value : 'z;
`else
  assign bus = enable ? value : '0;
`endif

endmodule

// File: rtl/program_counter.sv
// Program counter: async reset, bus load with priority over increment,
// output gated through bus_driver (Z when disabled if PC_TRISTATE_EN is defined).
module program_counter
  import cpu_pkg::*;
#(
  parameter int unsigned      WIDTH       = BUS_W,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET_VALUE)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_enable,
  input  logic             i_count,
  input  logic [WIDTH-1:0] i_bus,
`ifdef PC_TRISTATE_EN
  output wire logic [WIDTH-1:0] o_bus
`else
  output logic      [WIDTH-1:0] o_bus
`endif
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= RESET_VALUE;
    end else if (i_load) begin
      cnt <= i_bus;
    end else if (i_count) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

  bus_driver #(
    .WIDTH (WIDTH)
  ) u_bus_driver (
    .value  (cnt),
    .enable (i_enable),
    .bus    (o_bus)
  );

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter (default or PC_TRISTATE_EN build).
module tb_program_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic       enable;
  logic       count;
  logic [3:0] bus_in;
  wire  [3:0] bus_out;

  int unsigned total = 0;
  int unsigned bad   = 0;

`ifdef PC_TRISTATE_EN
  localparam logic [3:0] OFF = 4'bzzzz;
`else
  localparam logic [3:0] OFF = 4'b0000;
`endif

  program_counter #(
    .WIDTH       (4),
    .RESET_VALUE (4'h0)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_load   (load),
    .i_enable (enable),
    .i_count  (count),
    .i_bus    (bus_in),
    .o_bus    (bus_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] exp);
    total++;
    assert (bus_out === exp) else begin
      bad++;
      $error("FAIL %s: o_bus=%b expected=%b", tag, bus_out, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; enable = 1'b0; count = 1'b0; bus_in = 4'h0;

    // 1: reset held, count pulse ignored
    #1  check("rst_disabled", OFF);
    #99 enable = 1'b1;
    #1  check("rst_enabled", 4'h0);
    #49 count = 1'b1;
    #10 check("rst_count_mid", 4'h0);
    #10 count = 1'b0;
    check("rst_count_end", 4'h0);
    #3  rst = 1'b0;
    #1  check("post_rst", 4'h0);

    // 2: count three edges, then hold
    count = 1'b1;
    step(); check("cnt_1", 4'h1);
    step(); check("cnt_2", 4'h2);
    step(); check("cnt_3", 4'h3);
    count = 1'b0;
    step(); check("hold_3", 4'h3);

    // 3: load E then count through wrap
    bus_in = 4'hE; load = 1'b1;
    step(); check("load_e", 4'hE);
    load = 1'b0; count = 1'b1;
    step(); check("wrap_f", 4'hF);
    step(); check("wrap_0", 4'h0);
    step(); check("wrap_1", 4'h1);
    count = 1'b0;

    // 4: load beats count; disabled output while cnt=9
    bus_in = 4'h5; load = 1'b1;
    step(); check("load_5", 4'h5);
    bus_in = 4'h9; count = 1'b1;
    step(); check("load_prio", 4'h9);
    load = 1'b0; count = 1'b0; enable = 1'b0;
    #1 check("disabled_9", OFF);
    enable = 1'b1;
    #1 check("reenable_9", 4'h9);

    // 5: count four edges with output disabled
    bus_in = 4'h0; load = 1'b1;
    step(); check("load_0", 4'h0);
    load = 1'b0; count = 1'b1; enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); check("dis_count", OFF);
    end
    count = 1'b0;
    #2 enable = 1'b1;
    #1 check("enable_shows_4", 4'h4);

    // 6: mid-cycle reset with cnt=7; load/count edge during reset ignored
    bus_in = 4'h7; load = 1'b1;
    step(); check("load_7", 4'h7);
    load = 1'b0;
    #2 rst = 1'b1;
    #1 check("async_rst", 4'h0);
    bus_in = 4'hA; load = 1'b1; count = 1'b1;
    step(); check("rst_ignores_ctl", 4'h0);
    rst = 1'b0; load = 1'b0;
    step(); check("first_edge_after_rst", 4'h1);
    count = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- 4-bit program counter for the 8-bit breadboard-style CPU.
- Holds the address of the next instruction.
- Increments on command and can be loaded from the shared bus (jumps).
- Places its value on the bus only when output-enabled; the bus arbiter combines all module outputs.

Parameters:
WIDTH, 4, counter and bus width in bits.
RESET_VALUE, 0, value loaded on reset; must fit in WIDTH bits.

Ports:
i_clk  input  1  system clock; all state changes on rising edge.
i_rst  input  1  reset, asynchronous, active-high; clears counter to RESET_VALUE.
i_load  input  1  load counter from i_bus at next rising edge.
i_enable  input  1  output enable; drive counter value onto o_bus.
i_count  input  1  increment counter at next rising edge.
i_bus  input  WIDTH  bus value sampled when i_load=1.
o_bus  output  WIDTH  counter value when i_enable=1, else all zeros.

Behaviour:
- Single internal register cnt[WIDTH-1:0].
- Reset: i_rst=1 forces cnt=RESET_VALUE immediately, independent of i_clk, and holds it while asserted.
- With reset asserted, i_load and i_count are ignored and o_bus = (i_enable ? RESET_VALUE : 0).
- Reset deassertion needs no synchronisation inside the block; the first rising edge after deassertion may act on load/count.
- Rising edge with i_rst=0, evaluated in this priority order:
  - i_load=1: cnt <= i_bus. Load wins over count when both are asserted.
  - else i_count=1: cnt <= cnt+1, modulo 2^WIDTH. For WIDTH=4, 15 wraps to 0 with no flag.
  - else cnt holds.
- i_count held high for N consecutive rising edges advances cnt by N (mod 2^WIDTH). It is level-sensitive, not edge-detected.
- o_bus is combinational from cnt and i_enable, with zero-cycle latency:
  - Same-edge update is visible on o_bus after that edge.
  - i_enable changes propagate immediately.
- i_enable does not affect counting or loading; the counter advances while its output is disabled.
- No handshake; the controller guarantees one-cycle control pulses.
- All outputs are defined (never X) after the first reset.

Optional Feature:
PC_TRISTATE_EN:
- Defined: o_bus is driven to high-impedance (all bits Z) when i_enable=0, for a true shared tri-state bus. o_bus is declared as a net that allows Z.
- Undefined (default): o_bus is driven to all zeros when i_enable=0, which suits OR-combined or muxed FPGA buses.
- Counting, loading and reset are identical in both builds.

Decomposition:
- Shared package cpu_pkg holds:
  - BUS_W constant (4), used as the WIDTH default.
  - PC_RESET_VALUE constant (0).
  - A bus-word typedef of width BUS_W.
- One natural sub-module: bus_driver, parameterised by WIDTH.
  - Inputs: value and enable.
  - Output: bus value, with the zero-or-Z behaviour selected by PC_TRISTATE_EN.
  - Other CPU registers reuse it.
- Counter core stays in program_counter.

Test Plan:
1. i_rst=1 for 100 ns, i_enable=1 from 100 ns, i_count pulsed high 150–170 ns while reset still asserted -> o_bus stays 0 throughout; no increment.
2. Release reset, i_enable=1, i_count=1 for 3 rising edges -> o_bus 0,1,2,3 after successive edges. Then i_count=0 -> holds 3.
3. i_bus=4'hE, i_load=1 one edge, then i_count=1 for 3 edges -> o_bus E, F, 0, 1 (wrap checked).
4. i_load=1 and i_count=1 same edge with cnt=5, i_bus=9 -> cnt=9 (load priority). With i_enable=0 -> o_bus=0 (default build) or Z (PC_TRISTATE_EN) while cnt is still 9.
5. i_enable=0 while counting 4 edges from 0, then i_enable=1 -> o_bus reads 4 immediately, without waiting for a clock edge.
6. Assert i_rst mid-cycle (between edges) with cnt=7 -> o_bus drops to 0 before the next rising edge. The load/count edge during reset is ignored.
